// File: rtl/p_round.sv
// p_round: one registered round of the PRESENT-80 block cipher.
// Each accepted input is run through addRoundKey, the S-box layer and the
// bit-permutation layer, and the key register takes one key-schedule step.
// The outputs are registered, so the latency is one cycle and a new input
// can be accepted on every cycle.

module p_round (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [63:0] state,
    input  logic [79:0] keys,
    input  logic [4:0]  round_counter,
    output logic        out_valid,
    output logic [63:0] res,
    output logic [79:0] r_keys
);

    // PRESENT 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    logic [63:0] add_key;
    logic [63:0] s_out;
    logic [63:0] p_out;
    logic [79:0] k_next;

    // Combinational round: key add, S-box layer, P-layer and key-schedule step
    always_comb begin
        logic [5:0] base;
        logic [5:0] dst;
        add_key = state ^ keys[79:16];

        s_out = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            base = 6'(4 * i);
            s_out[base +: 4] = sbox(add_key[base +: 4]);
        end

        // Bit i moves to (16*i) mod 63; bit 63 is a fixed point.
        p_out = '0;
        for (int unsigned i = 0; i < 63; i++) begin
            dst = 6'((16 * i) % 63);
            p_out[dst] = s_out[6'(i)];
        end
        p_out[63] = s_out[63];

        k_next = {keys[18:0], keys[79:19]};
        k_next[79:76] = sbox(k_next[79:76]);
        k_next[19:15] = k_next[19:15] ^ round_counter;
    end

    // Output registers: capture on in_valid, hold otherwise, clear on reset
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            r_keys    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res    <= p_out;
                r_keys <= k_next;
            end
        end
    end

endmodule

// File: tb/tb_p_round.sv
// tb_p_round: scoreboard bench for p_round with directed vectors.
// Stimulus pushes expected round outputs into a queue; the monitor pops and
// compares whenever out_valid is seen. Hold and reset behaviour is checked
// directly against constant expectations.

module tb_p_round;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] state;
    logic [79:0] keys;
    logic [4:0]  round_counter;
    logic        out_valid;
    logic [63:0] res;
    logic [79:0] r_keys;

    typedef struct {
        string       name;
        bit          skip;     // intermediate feedback round, not compared
        bit          cipher;   // compare res ^ r_keys[79:16] against exp_res
        logic [63:0] exp_res;
        logic [79:0] exp_keys;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    p_round dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .state         (state),
        .keys          (keys),
        .round_counter (round_counter),
        .out_valid     (out_valid),
        .res           (res),
        .r_keys        (r_keys)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input string name, input bit skip, input bit cipher,
                        input logic [63:0] er, input logic [79:0] ek);
        exp_t e;
        e.name     = name;
        e.skip     = skip;
        e.cipher   = cipher;
        e.exp_res  = er;
        e.exp_keys = ek;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented output against the scoreboard head
    always @(negedge sys_clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 80'(out_valid), 80'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cipher) begin
                    chk(e.name, 80'(res ^ r_keys[79:16]), 80'(e.exp_res));
                end else if (!e.skip) begin
                    chk({e.name, "_res"}, 80'(res), 80'(e.exp_res));
                    chk({e.name, "_keys"}, r_keys, e.exp_keys);
                end
            end
        end
    end

    // Issue one valid round and queue its expected output
    task automatic vec(input string name, input logic [63:0] s, input logic [79:0] k,
                       input logic [4:0] rc, input logic [63:0] er, input logic [79:0] ek);
        state         = s;
        keys          = k;
        round_counter = rc;
        in_valid      = 1'b1;
        push(name, 1'b0, 1'b0, er, ek);
        step();
    endtask

    // 31 back-to-back rounds fed from the outputs; only the final ciphertext is checked
    task automatic full_cipher(input string name, input logic [63:0] pt,
                               input logic [79:0] key, input logic [63:0] ct);
        state         = pt;
        keys          = key;
        round_counter = 5'd1;
        in_valid      = 1'b1;
        push(name, 1'b1, 1'b0, '0, '0);
        step();
        for (int r = 2; r <= 31; r++) begin
            state         = res;
            keys          = r_keys;
            round_counter = 5'(r);
            push(name, (r != 31), (r == 31), ct, '0);
            step();
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b1;
        state         = {$urandom, $urandom};
        keys          = {16'($urandom), $urandom, $urandom};
        round_counter = 5'($urandom);
        step();
        state = {$urandom, $urandom};
        keys  = {16'($urandom), $urandom, $urandom};
        step();
        chk("reset_res", 80'(res), 80'd0);
        chk("reset_keys", r_keys, 80'd0);
        chk("reset_valid", 80'(out_valid), 80'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        vec("zero_vec", 64'h0, 80'h0, 5'd1,
            64'hFFFFFFFF00000000, 80'hC0000000000000008000);
        vec("rc31_vec", 64'h0, 80'h0, 5'd31,
            64'hFFFFFFFF00000000, 80'hC00000000000000F8000);
        vec("rc0_vec", 64'h0, 80'h0, 5'd0,
            64'hFFFFFFFF00000000, 80'hC0000000000000000000);
        vec("lsb_state_vec", 64'h1, 80'h0, 5'd1,
            64'hFFFEFFFF00000001, 80'hC0000000000000008000);
        vec("ones_vec", '1, '1, 5'd1,
            64'hFFFFFFFF00000000, 80'h2FFFFFFFFFFFFFFF7FFF);

        // Hold: inputs change while in_valid is low
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            state         = {$urandom, $urandom};
            keys          = {16'($urandom), $urandom, $urandom};
            round_counter = 5'($urandom);
            step();
            chk("hold_res", 80'(res), 80'(64'hFFFFFFFF00000000));
            chk("hold_keys", r_keys, 80'h2FFFFFFFFFFFFFFF7FFF);
            chk("hold_valid", 80'(out_valid), 80'd0);
        end

        full_cipher("cipher_zero", 64'h0, 80'h0, 64'h5579C1387B228445);
        full_cipher("cipher_ones", '1, '1, 64'h3333DCD3213210D2);

        // Reset mid-run: a valid round followed by rst while in_valid stays high
        vec("pre_reset_vec", 64'h0, 80'h0, 5'd1,
            64'hFFFFFFFF00000000, 80'hC0000000000000008000);
        state = '1;
        keys  = '1;
        rst   = 1'b1;
        step();
        chk("midrst_res", 80'(res), 80'd0);
        chk("midrst_keys", r_keys, 80'd0);
        chk("midrst_valid", 80'(out_valid), 80'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        step();

        chk("scoreboard_drained", 80'(exp_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
